// File: rtl/tl_pkg.sv
// Shared types, lamp encodings and phase helpers for the traffic-light sequencer.
// Optional feature macro: TL_NIGHT_MODE_EN (adds the NIGHT state).
package tl_pkg;

`ifdef TL_NIGHT_MODE_EN
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    NIGHT       = 3'd6
  } phase_t;
`else
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } phase_t;
`endif

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  typedef struct packed {
    logic [3:0] ten;
    logic [3:0] unit;
  } bcd2_t;

  // Duration loaded on entry to phase p; durations are passed in so the
  // top-level parameters stay overridable per instance.
  function automatic bcd2_t phase_duration(input phase_t p, input bcd2_t t_mg,
                                           input bcd2_t t_sg, input bcd2_t t_y,
                                           input bcd2_t t_ar);
    bcd2_t d;
    case (p)
      MAIN_GREEN:  d = t_mg;
      MAIN_YELLOW: d = t_y;
      ALL_RED_A:   d = t_ar;
      SIDE_GREEN:  d = t_sg;
      SIDE_YELLOW: d = t_y;
      ALL_RED_B:   d = t_ar;
      default:     d = 8'h00;
    endcase
    return d;
  endfunction

  // Fixed phase rotation; anything unexpected recovers through ALL_RED_B.
  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      MAIN_GREEN:  n = MAIN_YELLOW;
      MAIN_YELLOW: n = ALL_RED_A;
      ALL_RED_A:   n = SIDE_GREEN;
      SIDE_GREEN:  n = SIDE_YELLOW;
      SIDE_YELLOW: n = ALL_RED_B;
      ALL_RED_B:   n = MAIN_GREEN;
      default:     n = ALL_RED_B;
    endcase
    return n;
  endfunction

  // Lamp pattern {main, side} for a phase; unknown phases show all red.
  function automatic logic [5:0] phase_lamps(input phase_t p);
    logic [5:0] l;
    case (p)
      MAIN_GREEN:  l = {LT_GRN, LT_RED};
      MAIN_YELLOW: l = {LT_YEL, LT_RED};
      SIDE_GREEN:  l = {LT_RED, LT_GRN};
      SIDE_YELLOW: l = {LT_RED, LT_YEL};
      default:     l = {LT_RED, LT_RED};
    endcase
    return l;
  endfunction

  function automatic logic bcd_ok(input bcd2_t v);
    return (v.ten <= 4'd9) && (v.unit <= 4'd9);
  endfunction

endpackage

// File: rtl/tl_bcd_step.sv
// Two-digit BCD arithmetic: saturating add (clamps at 99) then optional decrement.
module tl_bcd_step
  import tl_pkg::*;
(
  input  bcd2_t cur_i,
  input  bcd2_t add_i,
  input  logic  add_en_i,
  input  logic  dec_en_i,
  output bcd2_t res_o
);

  logic [4:0] unit_sum_s;
  logic [4:0] ten_sum_s;
  bcd2_t      sum_s;

  // Digit-wise add with carry, saturate on tens overflow, then step down by one.
  always_comb begin
    unit_sum_s = 5'd0;
    ten_sum_s  = 5'd0;
    sum_s      = cur_i;
    res_o      = cur_i;
    if (add_en_i) begin
      unit_sum_s = {1'b0, cur_i.unit} + {1'b0, add_i.unit};
      ten_sum_s  = {1'b0, cur_i.ten} + {1'b0, add_i.ten};
      if (unit_sum_s > 5'd9) begin
        unit_sum_s = unit_sum_s - 5'd10;
        ten_sum_s  = ten_sum_s + 5'd1;
      end else begin
        unit_sum_s = unit_sum_s;
      end
      if (ten_sum_s > 5'd9) begin
        sum_s = 8'h99;
      end else begin
        sum_s = {ten_sum_s[3:0], unit_sum_s[3:0]};
      end
    end else begin
      sum_s = cur_i;
    end
    if (dec_en_i) begin
      if (sum_s.unit == 4'd0) begin
        res_o = {sum_s.ten - 4'd1, 4'd9};
      end else begin
        res_o = {sum_s.ten, sum_s.unit - 4'd1};
      end
    end else begin
      res_o = sum_s;
    end
  end

endmodule

// File: rtl/tl_phase_sequencer_chk.sv
// Simulation checks: legal duration parameters and no conflicting green/yellow lamps.
module tl_phase_sequencer_chk
  import tl_pkg::*;
#(
  parameter logic [7:0] T_MAIN_GREEN = 8'h30,
  parameter logic [7:0] T_SIDE_GREEN = 8'h20,
  parameter logic [7:0] T_YELLOW     = 8'h03,
  parameter logic [7:0] T_ALL_RED    = 8'h02,
  parameter logic [7:0] T_EXT        = 8'h10
) (
  input logic       clk,
  input logic       rst_n,
  input phase_t     phase_i,
  input logic [2:0] main_light_i,
  input logic [2:0] side_light_i
);

  logic params_ok_s;
  logic lamps_ok_s;

  assign params_ok_s = bcd_ok(T_MAIN_GREEN) && bcd_ok(T_SIDE_GREEN) && bcd_ok(T_YELLOW)
                    && bcd_ok(T_ALL_RED) && bcd_ok(T_EXT)
                    && (T_MAIN_GREEN != 8'h00) && (T_SIDE_GREEN != 8'h00)
                    && (T_YELLOW != 8'h00) && (T_ALL_RED != 8'h00);

`ifdef TL_NIGHT_MODE_EN
  assign lamps_ok_s = (phase_i == NIGHT) || (main_light_i == LT_RED) || (side_light_i == LT_RED);
`else
  assign lamps_ok_s = (main_light_i == LT_RED) || (side_light_i == LT_RED) || (phase_i == ALL_RED_B && 1'b0);
`endif

  // Sample both properties on every clock outside reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (params_ok_s) else $error("tl_phase_sequencer: illegal duration parameter");
      assert (lamps_ok_s) else $error("tl_phase_sequencer: main and side both non-red");
    end
  end

endmodule

// File: rtl/tl_phase_sequencer.sv
// Two-road phase sequencer with per-phase BCD countdown and one green extension.
// Optional feature macro: TL_NIGHT_MODE_EN (night_mode port, flashing-yellow NIGHT state).
module tl_phase_sequencer
  import tl_pkg::*;
#(
  parameter logic [7:0] T_MAIN_GREEN = 8'h30,
  parameter logic [7:0] T_SIDE_GREEN = 8'h20,
  parameter logic [7:0] T_YELLOW     = 8'h03,
  parameter logic [7:0] T_ALL_RED    = 8'h02,
  parameter logic [7:0] T_EXT        = 8'h10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       run,
  input  logic       ext_req,
`ifdef TL_NIGHT_MODE_EN
  input  logic       night_mode,
`endif
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [3:0] cnt_ten,
  output logic [3:0] cnt_unit,
  output logic [2:0] phase,
  output logic       ext_used
);

  phase_t     phase_q, phase_d;
  bcd2_t      count_q, count_d;
  logic       ext_used_q, ext_used_d;
  logic [2:0] main_q, main_d, side_q, side_d;

  logic  tick_run_s, ext_ok_s, ext_adds_s, advance_s;
  bcd2_t step_res_s;

  assign tick_run_s = run & tick_1hz;
  assign ext_ok_s   = run & ext_req & ~ext_used_q
                    & ((phase_q == MAIN_GREEN) | (phase_q == SIDE_GREEN));
  // A zero-length extension still consumes the request but must not block the advance.
  assign ext_adds_s = ext_ok_s & (T_EXT != 8'h00);
  assign advance_s  = tick_run_s & (count_q == 8'h01) & ~ext_adds_s;

  tl_bcd_step u_step (
    .cur_i    (count_q),
    .add_i    (T_EXT),
    .add_en_i (ext_adds_s),
    .dec_en_i (tick_run_s),
    .res_o    (step_res_s)
  );

  // Next-state selection: night override, phase advance, or count/extension update.
  always_comb begin
    phase_d    = phase_q;
    count_d    = count_q;
    ext_used_d = ext_used_q;
    main_d     = main_q;
    side_d     = side_q;
`ifdef TL_NIGHT_MODE_EN
    if (night_mode) begin
      phase_d    = NIGHT;
      count_d    = 8'h00;
      ext_used_d = 1'b0;
      if (phase_q != NIGHT) begin
        main_d = LT_YEL;
        side_d = LT_YEL;
      end else if (tick_1hz) begin
        main_d = main_q ^ LT_YEL;
        side_d = side_q ^ LT_YEL;
      end else begin
        main_d = main_q;
        side_d = side_q;
      end
    end else if (phase_q == NIGHT) begin
      phase_d    = ALL_RED_B;
      count_d    = T_ALL_RED;
      ext_used_d = 1'b0;
      main_d     = LT_RED;
      side_d     = LT_RED;
    end else begin
`else
    begin
`endif
      if (advance_s) begin
        phase_d    = next_phase(phase_q);
        count_d    = phase_duration(next_phase(phase_q), T_MAIN_GREEN, T_SIDE_GREEN,
                                    T_YELLOW, T_ALL_RED);
        ext_used_d = 1'b0;
      end else begin
        count_d    = step_res_s;
        ext_used_d = ext_used_q | ext_ok_s;
      end
      {main_d, side_d} = phase_lamps(phase_d);
    end
  end

  // State, count and lamp registers; reset parks the junction in all-red clearance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= ALL_RED_B;
      count_q    <= T_ALL_RED;
      ext_used_q <= 1'b0;
      main_q     <= LT_RED;
      side_q     <= LT_RED;
    end else begin
      phase_q    <= phase_d;
      count_q    <= count_d;
      ext_used_q <= ext_used_d;
      main_q     <= main_d;
      side_q     <= side_d;
    end
  end

  assign main_light = main_q;
  assign side_light = side_q;
  assign cnt_ten    = count_q.ten;
  assign cnt_unit   = count_q.unit;
  assign phase      = phase_q;
  assign ext_used   = ext_used_q;

  tl_phase_sequencer_chk #(
    .T_MAIN_GREEN (T_MAIN_GREEN),
    .T_SIDE_GREEN (T_SIDE_GREEN),
    .T_YELLOW     (T_YELLOW),
    .T_ALL_RED    (T_ALL_RED),
    .T_EXT        (T_EXT)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .phase_i      (phase_q),
    .main_light_i (main_q),
    .side_light_i (side_q)
  );

endmodule

// File: tb/tb_tl_phase_sequencer.sv
// Directed self-checking bench for tl_phase_sequencer (default and T_EXT=95 instances).
module tb_tl_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic       run;
  logic       ext_req;
  logic       night_mode;
  logic [2:0] main_light, side_light, phase;
  logic [3:0] cnt_ten, cnt_unit;
  logic       ext_used;
  logic [2:0] main_light95, side_light95, phase95;
  logic [3:0] cnt_ten95, cnt_unit95;
  logic       ext_used95;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tl_phase_sequencer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .run        (run),
    .ext_req    (ext_req),
`ifdef TL_NIGHT_MODE_EN
    .night_mode (night_mode),
`endif
    .main_light (main_light),
    .side_light (side_light),
    .cnt_ten    (cnt_ten),
    .cnt_unit   (cnt_unit),
    .phase      (phase),
    .ext_used   (ext_used)
  );

  tl_phase_sequencer #(.T_EXT(8'h95)) u_dut95 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .run        (run),
    .ext_req    (ext_req),
`ifdef TL_NIGHT_MODE_EN
    .night_mode (night_mode),
`endif
    .main_light (main_light95),
    .side_light (side_light95),
    .cnt_ten    (cnt_ten95),
    .cnt_unit   (cnt_unit95),
    .phase      (phase95),
    .ext_used   (ext_used95)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ph, input logic [7:0] cnt,
                           input logic [2:0] ml, input logic [2:0] sl, input logic eu);
    chk({tag, ".phase"}, {29'd0, phase}, {29'd0, ph});
    chk({tag, ".count"}, {24'd0, cnt_ten, cnt_unit}, {24'd0, cnt});
    chk({tag, ".main"}, {29'd0, main_light}, {29'd0, ml});
    chk({tag, ".side"}, {29'd0, side_light}, {29'd0, sl});
    chk({tag, ".ext_used"}, {31'd0, ext_used}, {31'd0, eu});
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] cnt);
    chk(tag, {24'd0, cnt_ten, cnt_unit}, {24'd0, cnt});
  endtask

  task automatic chk_cnt95(input string tag, input logic [7:0] cnt);
    chk(tag, {24'd0, cnt_ten95, cnt_unit95}, {24'd0, cnt});
  endtask

  // One clock with the given strobes; outputs are stable 1 time unit after the edge.
  task automatic step(input logic t, input logic e);
    tick_1hz = t;
    ext_req  = e;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    ext_req  = 1'b0;
  endtask

  // n seconds, one tick every 4 clocks.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; tick_1hz = 1'b0; ext_req = 1'b0; night_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    rst_n = 1'b1;
    run   = 1'b1;

    // Full rotation with default durations.
    tick_n(2);  chk_state("mg_entry", 3'd0, 8'h30, 3'b001, 3'b100, 1'b0);
    tick_n(20); chk_cnt("mg_10", 8'h10);
    tick_n(1);  chk_cnt("mg_bcd_borrow", 8'h09);
    tick_n(8);  chk_cnt("mg_01", 8'h01);
    tick_n(1);  chk_state("my_entry", 3'd1, 8'h03, 3'b010, 3'b100, 1'b0);
    tick_n(3);  chk_state("ara_entry", 3'd2, 8'h02, 3'b100, 3'b100, 1'b0);
    tick_n(2);  chk_state("sg_entry", 3'd3, 8'h20, 3'b100, 3'b001, 1'b0);
    tick_n(20); chk_state("sy_entry", 3'd4, 8'h03, 3'b100, 3'b010, 1'b0);
    tick_n(3);  chk_state("arb_entry", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    tick_n(2);  chk_state("mg_again", 3'd0, 8'h30, 3'b001, 3'b100, 1'b0);

    // Extension at 07, then a second request is ignored.
    tick_n(23); chk_cnt("mg_07", 8'h07);
    step(1'b0, 1'b1);
    chk_state("ext_07", 3'd0, 8'h17, 3'b001, 3'b100, 1'b1);
    chk_cnt95("ext95_from_07", 8'h99);
    step(1'b0, 1'b1);
    chk_cnt("ext_second_ignored", 8'h17);
    tick_n(1); chk_cnt("ext_then_tick", 8'h16);

    // Asynchronous reset mid-phase.
    rst_n = 1'b0;
    #2;
    chk_state("reset_mid", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Saturation: 25 + 95 clamps to 99.
    tick_n(7);
    chk_cnt95("pre_ext95_25", 8'h25);
    step(1'b0, 1'b1);
    chk_cnt95("ext95_sat", 8'h99);
    chk("ext95_used", {31'd0, ext_used95}, 32'd1);
    chk_cnt("ext_25_to_35", 8'h35);

    // run = 0 freezes count and phase.
    tick_n(23); chk_cnt("pre_freeze_12", 8'h12);
    run = 1'b0;
    tick_n(10);
    step(1'b0, 1'b1);
    chk_state("frozen", 3'd0, 8'h12, 3'b001, 3'b100, 1'b1);
    run = 1'b1;
    tick_n(1); chk_cnt("resume_11", 8'h11);

    // Extension coinciding with the final tick of SIDE_GREEN.
    tick_n(11); chk_state("my_2", 3'd1, 8'h03, 3'b010, 3'b100, 1'b0);
    tick_n(5);  chk_state("sg_2", 3'd3, 8'h20, 3'b100, 3'b001, 1'b0);
    tick_n(19); chk_cnt("sg_01", 8'h01);
    step(1'b1, 1'b1);
    chk_state("sg_ext_tick", 3'd3, 8'h10, 3'b100, 3'b001, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    tick_n(1); chk_state("sg_09", 3'd3, 8'h09, 3'b100, 3'b001, 1'b1);

`ifdef TL_NIGHT_MODE_EN
    night_mode = 1'b1;
    step(1'b0, 1'b0);
    chk_state("night_entry", 3'd6, 8'h00, 3'b010, 3'b010, 1'b0);
    tick_n(1); chk_state("night_off", 3'd6, 8'h00, 3'b000, 3'b000, 1'b0);
    tick_n(1); chk_state("night_on", 3'd6, 8'h00, 3'b010, 3'b010, 1'b0);
    night_mode = 1'b0;
    step(1'b0, 1'b0);
    chk_state("night_exit", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
